prbs_stream_checker: RTL and testbench

//  Receiving end of the bench stimulus path: a synthesizable self-checking sink

---
 rtl/prbs_stream_checker.sv | 177 +++++++++++++++++
 tb/tb_prbs_stream_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_stream_checker
// Brief    : Valid/ready stream sink that checks every beat against a 16-bit
//            LFSR reference and reports counts, first failing index and pass.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_stream_checker #(
    parameter int          DATA_W      = 8,
    parameter int          NUM_WORDS   = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic                               clk_tb,
    input  logic                               rst_tb,
    input  logic                               start,
    input  logic                               in_valid,
    input  logic [DATA_W-1:0]                  in_data,
    output logic                               in_ready,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               timeout,
    output logic [$clog2(NUM_WORDS+1)-1:0]     word_count,
    output logic [$clog2(NUM_WORDS+1)-1:0]     err_count,
    output logic [$clog2(NUM_WORDS+1)-1:0]     first_err_idx
);

    localparam int c_cw = $clog2(NUM_WORDS + 1);
    // Idle counter only ever holds 0..TIMEOUT_CYC-1; reaching the top ends the run.
    localparam int c_iw = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [c_iw-1:0] c_idle_max = c_iw'(TIMEOUT_CYC - 1);
    localparam logic [c_cw-1:0] c_last_idx = c_cw'(NUM_WORDS - 1);
    localparam logic [c_cw-1:0] c_err_sat  = c_cw'(NUM_WORDS);
    localparam logic [c_cw-1:0] c_no_err   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [15:0]         r_lfsr;
    logic [15:0]         w_lfsr_nxt;
    logic [c_cw-1:0]     r_word_cnt;
    logic [c_cw-1:0]     r_err_cnt;
    logic [c_cw-1:0]     w_err_nxt;
    logic [c_cw-1:0]     r_first_err;
    logic [c_iw-1:0]     r_idle_cnt;
    logic                r_pass;
    logic                r_timeout;

    logic                w_run;
    logic                w_accept;
    logic                w_mismatch;
    logic                w_last_beat;
    logic                w_idle_expire;
    logic                w_start_run;

    // ------------------------------------------------------------------------
    // Beat decode
    // ------------------------------------------------------------------------
    assign w_run         = (r_state == ST_RUN);
    assign w_accept      = in_valid & w_run;
    assign w_mismatch    = (in_data != r_lfsr[DATA_W-1:0]);
    assign w_last_beat   = (r_word_cnt == c_last_idx);
    assign w_idle_expire = w_run & ~w_accept & (r_idle_cnt == c_idle_max);
    assign w_lfsr_nxt    = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_comb begin
        w_err_nxt = r_err_cnt;
        if (w_mismatch && (r_err_cnt < c_err_sat)) begin
            w_err_nxt = r_err_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_tb or negedge rst_tb) begin
        if (!rst_tb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end else if (w_idle_expire) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start here wins over any beat: in_ready is low in DONE.
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_start_run = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Reference generator and result counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_tb or negedge rst_tb) begin
        if (!rst_tb) begin
            r_lfsr      <= SEED;
            r_word_cnt  <= '0;
            r_err_cnt   <= '0;
            r_first_err <= c_no_err;
            r_idle_cnt  <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (w_start_run) begin
            r_lfsr      <= SEED;
            r_word_cnt  <= '0;
            r_err_cnt   <= '0;
            r_first_err <= c_no_err;
            r_idle_cnt  <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (w_accept) begin
            r_err_cnt  <= w_err_nxt;
            r_word_cnt <= r_word_cnt + 1'b1;
            r_lfsr     <= w_lfsr_nxt;
            r_idle_cnt <= '0;
            if (w_mismatch && (r_first_err == c_no_err)) begin
                r_first_err <= r_word_cnt;
            end
            // Verdict lands on the same edge that moves the FSM to DONE.
            if (w_last_beat) begin
                r_pass <= (w_err_nxt == '0);
            end
        end else if (w_run) begin
            if (w_idle_expire) begin
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready      = w_run;
    assign busy          = w_run;
    assign done          = (r_state == ST_DONE);
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign word_count    = r_word_cnt;
    assign err_count     = r_err_cnt;
    assign first_err_idx = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_prbs_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_stream_checker
// Brief    : Directed bench for prbs_stream_checker with a per-cycle
//            index-based reference model and literal end-of-run checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_stream_checker;

    localparam int          DATA_W      = 8;
    localparam int          NUM_WORDS   = 16;
    localparam logic [15:0] SEED        = 16'hACE1;
    localparam int          TIMEOUT_CYC = 64;
    localparam int          CW          = $clog2(NUM_WORDS + 1);

    logic              clk_tb = 1'b0;
    logic              rst_tb = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, busy, done, pass, timeout;
    logic [CW-1:0]     word_count, err_count, first_err_idx;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    prbs_stream_checker #(
        .DATA_W      (DATA_W),
        .NUM_WORDS   (NUM_WORDS),
        .SEED        (SEED),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_tb        (clk_tb),
        .rst_tb        (rst_tb),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .word_count    (word_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk_tb = ~clk_tb;

    // Reference word for beat n: the sequence value n steps after SEED.
    function automatic logic [DATA_W-1:0] beat_word(input int n);
        logic [15:0] l;
        l = SEED;
        for (int k = 0; k < n; k++) begin
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return l[DATA_W-1:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: phase 0 idle, 1 running, 2 finished; beats tracked by index.
    // ------------------------------------------------------------------------
    int m_phase = 0;
    int m_idx   = 0;
    int m_errs  = 0;
    int m_first = -1;
    int m_idle  = 0;
    bit m_to    = 1'b0;
    bit m_pass  = 1'b0;

    always @(posedge clk_tb or negedge rst_tb) begin
        if (!rst_tb) begin
            m_phase = 0; m_idx = 0; m_errs = 0; m_first = -1;
            m_idle = 0; m_to = 1'b0; m_pass = 1'b0;
        end else if (m_phase != 1) begin
            if (start) begin
                m_phase = 1; m_idx = 0; m_errs = 0; m_first = -1;
                m_idle = 0; m_to = 1'b0; m_pass = 1'b0;
            end
        end else if (in_valid) begin
            if (in_data != beat_word(m_idx)) begin
                if (m_errs < NUM_WORDS) m_errs++;
                if (m_first < 0) m_first = m_idx;
            end
            m_idx++;
            m_idle = 0;
            if (m_idx == NUM_WORDS) begin
                m_phase = 2;
                m_pass  = (m_errs == 0);
            end
        end else if (m_idle == TIMEOUT_CYC - 1) begin
            m_phase = 2; m_to = 1'b1; m_pass = 1'b0;
        end else begin
            m_idle++;
        end
    end

    always @(negedge clk_tb) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_phase == 1);
            check("busy", busy, m_phase == 1);
            check("done", done, m_phase == 2);
            check("pass", pass, m_pass);
            check("timeout", timeout, m_to);
            check("word_count", word_count, m_idx);
            check("err_count", err_count, m_errs);
            check("first_err_idx", first_err_idx, (m_first < 0) ? 31 : m_first);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all input changes happen on the falling edge)
    // ------------------------------------------------------------------------
    task automatic start_pulse(input bit valid_too);
        @(negedge clk_tb);
        start    = 1'b1;
        in_valid = valid_too;
        in_data  = DATA_W'($urandom);
        @(negedge clk_tb);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_beats(input int from, input int upto, input logic [15:0] bad, input int max_gap);
        for (int i = from; i < upto; i++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                in_valid = 1'b0;
                repeat (g) begin
                    in_data = DATA_W'($urandom);
                    @(negedge clk_tb);
                end
            end
            in_valid = 1'b1;
            in_data  = beat_word(i) ^ (bad[i] ? 8'h5A : 8'h00);
            @(negedge clk_tb);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit && !done; i++) @(negedge clk_tb);
        check(name, done, 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [DATA_W-1:0] w;
        int cyc;

        w = beat_word(0);
        check("model_beat0", w, 8'hE1);
        w = beat_word(1);
        check("model_beat1", w, 8'hC3);

        #2 rst_tb = 1'b0;
        #20 rst_tb = 1'b1;
        @(negedge clk_tb);
        chk_en = 1'b1;

        // Beats offered in IDLE are ignored.
        in_valid = 1'b1;
        in_data  = 8'hE1;
        repeat (3) @(negedge clk_tb);
        check("idle_ready", in_ready, 0);
        check("idle_wc", word_count, 0);
        in_valid = 1'b0;

        // 1: clean run
        start_pulse(1'b0);
        send_beats(0, NUM_WORDS, 16'h0000, 0);
        wait_done("t1_done", 100);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_wc", word_count, 16);
        check("t1_first", first_err_idx, 5'h1F);

        // 2: beats 3 and 9 corrupted
        start_pulse(1'b0);
        send_beats(0, NUM_WORDS, 16'h0208, 0);
        wait_done("t2_done", 100);
        check("t2_err", err_count, 2);
        check("t2_first", first_err_idx, 3);
        check("t2_pass", pass, 0);

        // 3: random valid gaps
        start_pulse(1'b0);
        send_beats(0, NUM_WORDS, 16'h0000, 10);
        wait_done("t3_done", 400);
        check("t3_pass", pass, 1);
        check("t3_wc", word_count, 16);

        // 4: stall after five beats
        start_pulse(1'b0);
        send_beats(0, 5, 16'h0000, 0);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk_tb);
            cyc++;
        end
        check("t4_latency", cyc, 64);
        check("t4_timeout", timeout, 1);
        check("t4_pass", pass, 0);
        check("t4_wc", word_count, 5);

        // 5: asynchronous reset mid-run, beat 7 in flight
        start_pulse(1'b0);
        send_beats(0, 7, 16'h0000, 0);
        in_valid = 1'b1;
        in_data  = beat_word(7);
        #2 rst_tb = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_ready", in_ready, 0);
        check("t5_done", done, 0);
        check("t5_wc", word_count, 0);
        check("t5_err", err_count, 0);
        check("t5_first", first_err_idx, 5'h1F);
        check("t5_pass", pass, 0);
        check("t5_timeout", timeout, 0);
        #1 rst_tb = 1'b1;
        @(negedge clk_tb);
        in_valid = 1'b0;
        start_pulse(1'b0);
        send_beats(0, NUM_WORDS, 16'h0000, 0);
        wait_done("t5_rerun_done", 100);
        check("t5_rerun_pass", pass, 1);

        // 6: start during RUN is ignored, start in DONE wins over a beat
        start_pulse(1'b0);
        send_beats(0, 4, 16'h0000, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = beat_word(4);
        @(negedge clk_tb);
        start    = 1'b0;
        check("t6_wc_mid", word_count, 5);
        send_beats(5, NUM_WORDS, 16'h0000, 0);
        wait_done("t6_done", 100);
        check("t6_pass", pass, 1);
        start_pulse(1'b1);
        check("t6_restart_wc", word_count, 0);
        send_beats(0, NUM_WORDS, 16'h0000, 0);
        wait_done("t6_rerun_done", 100);
        check("t6_rerun_pass", pass, 1);
        check("t6_rerun_wc", word_count, 16);

        @(negedge clk_tb);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
